// File: rtl/store_rmw_unit.sv
// store_rmw_unit: executes sb/sh/sw/sd against a 64-bit data memory.
// Sub-doubleword stores do a read-modify-write of the aligned doubleword
// (little-endian byte merge); sd writes REG_DATA unchanged.
// Optional feature macro: STORE_SD_BYPASS_EN -- aligned sd skips the read
// phase and goes straight to WRITE. Without it every type does the read.
module store_rmw_unit #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        START,
  input  logic [1:0]  STORE_TYPE,
  input  logic [63:0] ADDR,
  input  logic [63:0] REG_DATA,
  input  logic [63:0] MEM_RDATA,
  output logic [63:0] MEM_ADDR,
  output logic [63:0] MEM_WDATA,
  output logic        MEM_WR,
  output logic        BUSY,
  output logic        DONE,
  output logic        MISALIGN
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;
  localparam logic [1:0] ST_SD = 2'b11;

  // Last read-phase count: capture happens when the counter reaches it.
  localparam logic [2:0] RD_LAST = 3'(RD_LATENCY - 32'd1);

  // Natural alignment check on the byte offset within the doubleword.
  function automatic logic f_aligned(input logic [1:0] t, input logic [2:0] off);
    logic ok;
    case (t)
      ST_SB:   ok = 1'b1;
      ST_SH:   ok = (off[0] == 1'b0);
      ST_SW:   ok = (off[1:0] == 2'b00);
      ST_SD:   ok = (off == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Little-endian merge of the low register bytes into the old doubleword.
  // For sd the offset is always zero, so the full mask yields REG_DATA.
  function automatic logic [63:0] f_merge(input logic [1:0]  t,
                                          input logic [2:0]  off,
                                          input logic [63:0] data,
                                          input logic [63:0] old);
    logic [5:0]  sh;
    logic [63:0] mask;
    logic [63:0] ins;
    sh = {off, 3'b000};
    case (t)
      ST_SB:   mask = 64'h0000_0000_0000_00FF;
      ST_SH:   mask = 64'h0000_0000_0000_FFFF;
      ST_SW:   mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    mask = mask << sh;
    ins  = data << sh;
    return (old & ~mask) | (ins & mask);
  endfunction

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_type;
  logic [2:0]  r_off;
  logic [63:0] r_data;
  logic [63:0] r_mem_addr;
  logic [63:0] r_mem_wdata;
  logic        r_mem_wr;
  logic        r_busy;
  logic        r_done;
  logic        r_misalign;

  logic        w_aligned;
  logic [63:0] w_merged;

  assign w_aligned = f_aligned(STORE_TYPE, ADDR[2:0]);
  assign w_merged  = f_merge(r_type, r_off, r_data, MEM_RDATA);

  // Control FSM with registered memory-port and handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_type      <= 2'b00;
      r_off       <= 3'd0;
      r_data      <= 64'd0;
      r_mem_addr  <= 64'd0;
      r_mem_wdata <= 64'd0;
      r_mem_wr    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_mem_wr <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_type <= STORE_TYPE;
            r_off  <= ADDR[2:0];
            r_data <= REG_DATA;
            r_busy <= 1'b1;
            if (!w_aligned) begin
              // Dropped store: report immediately, never touch memory.
              r_state    <= S_FIN;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
            end else begin
              r_mem_addr <= {ADDR[63:3], 3'b000};
              r_misalign <= 1'b0;
`ifdef STORE_SD_BYPASS_EN
              if (STORE_TYPE == ST_SD) begin
                r_state     <= S_WRITE;
                r_mem_wr    <= 1'b1;
                r_mem_wdata <= REG_DATA;
              end else begin
                r_state <= S_READ;
                r_cnt   <= 3'd0;
              end
`else
              r_state <= S_READ;
              r_cnt   <= 3'd0;
`endif
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READ: begin
          if (r_cnt == RD_LAST) begin
            // Read data is valid this cycle: merge and issue the write.
            r_mem_wdata <= w_merged;
            r_mem_wr    <= 1'b1;
            r_state     <= S_WRITE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_WRITE: begin
          r_state <= S_FIN;
          r_done  <= 1'b1;
        end
        S_FIN: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_misalign <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;
  assign MEM_WR    = r_mem_wr;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign MISALIGN  = r_misalign;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit: one instance with RD_LATENCY=1 and one
// with RD_LATENCY=3. The memory models return valid data only in the cycle
// the unit is expected to capture it.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  store_type = 2'b00;
  logic [63:0] addr = 64'd0;
  logic [63:0] reg_data = 64'd0;

  logic        start1 = 1'b0;
  logic [63:0] rdata1, mem_addr1, mem_wdata1;
  logic        mem_wr1, busy1, done1, misalign1;

  logic        start3 = 1'b0;
  logic [63:0] rdata3, mem_addr3, mem_wdata3;
  logic        mem_wr3, busy3, done3, misalign3;

  int n_pass = 0;
  int n_total = 0;
  int bc1 = 0;
  int bc3 = 0;

  localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

  always #5 clk = ~clk;

  store_rmw_unit #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .START(start1), .STORE_TYPE(store_type),
    .ADDR(addr), .REG_DATA(reg_data), .MEM_RDATA(rdata1),
    .MEM_ADDR(mem_addr1), .MEM_WDATA(mem_wdata1), .MEM_WR(mem_wr1),
    .BUSY(busy1), .DONE(done1), .MISALIGN(misalign1)
  );

  store_rmw_unit #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .START(start3), .STORE_TYPE(store_type),
    .ADDR(addr), .REG_DATA(reg_data), .MEM_RDATA(rdata3),
    .MEM_ADDR(mem_addr3), .MEM_WDATA(mem_wdata3), .MEM_WR(mem_wr3),
    .BUSY(busy3), .DONE(done3), .MISALIGN(misalign3)
  );

  function automatic logic [63:0] memval(input logic [63:0] a);
    return (a == 64'h100) ? 64'h1122_3344_5566_7788 : 64'h0123_4567_89AB_CDEF;
  endfunction

  // Cycles spent busy so far; 0 in the first busy cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bc1 <= 0;
      bc3 <= 0;
    end else begin
      bc1 <= busy1 ? bc1 + 1 : 0;
      bc3 <= busy3 ? bc3 + 1 : 0;
    end
  end

  always_comb begin
    rdata1 = (busy1 && bc1 == 0) ? memval(mem_addr1) : BAD;
    rdata3 = (busy3 && bc3 == 2) ? memval(mem_addr3) : BAD;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // One store on the RD_LATENCY=1 instance; latency counted in cycles from START.
  task automatic run1(input logic [1:0] t, input logic [63:0] a, input logic [63:0] d,
                      output int lat, output int wrs, output logic [63:0] wd,
                      output logic [63:0] ma, output logic mis, output logic bz);
    lat = 0; wrs = 0; wd = 64'd0; ma = 64'd0; mis = 1'b0; bz = 1'b0;
    @(negedge clk);
    store_type = t; addr = a; reg_data = d; start1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start1 = 1'b0;
        addr = 64'hFFFF_FFFF_FFFF_FFF8;
        reg_data = 64'h5555_5555_5555_5555;
      end
      if (mem_wr1) begin
        wrs++;
        wd = mem_wdata1;
        ma = mem_addr1;
      end
      if (done1) begin
        lat = k;
        mis = misalign1;
        bz = busy1;
        break;
      end
    end
    @(negedge clk);
  endtask

  int lat, wrs, dones;
  logic [63:0] wd, ma;
  logic mis, bz;
  int exp_sd_lat;

  initial begin
`ifdef STORE_SD_BYPASS_EN
    exp_sd_lat = 2;
`else
    exp_sd_lat = 3;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy1}, 64'd0);
    check("rst_done", {63'd0, done1}, 64'd0);
    check("rst_wr", {63'd0, mem_wr1}, 64'd0);
    check("rst_addr", mem_addr1, 64'd0);
    check("rst_wdata", mem_wdata1, 64'd0);
    check("rst_mis", {63'd0, misalign1}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // sb into byte 3
    run1(2'b00, 64'h103, 64'hFFAB, lat, wrs, wd, ma, mis, bz);
    check("sb_wdata", wd, 64'h1122_3344_AB66_7788);
    check("sb_addr", ma, 64'h100);
    check("sb_lat", 64'(lat), 64'd3);
    check("sb_wrs", 64'(wrs), 64'd1);
    check("sb_mis", {63'd0, mis}, 64'd0);
    check("sb_busy_fin", {63'd0, bz}, 64'd1);
    check("sb_idle", {63'd0, busy1}, 64'd0);
    check("sb_hold", mem_wdata1, 64'h1122_3344_AB66_7788);

    // sh into top halfword
    run1(2'b01, 64'h106, 64'h1234_BEEF, lat, wrs, wd, ma, mis, bz);
    check("sh_wdata", wd, 64'hBEEF_3344_5566_7788);
    check("sh_wrs", 64'(wrs), 64'd1);
    check("sh_lat", 64'(lat), 64'd3);

    // misaligned sw
    run1(2'b10, 64'h102, 64'hCAFE_F00D, lat, wrs, wd, ma, mis, bz);
    check("sw_mis_lat", 64'(lat), 64'd1);
    check("sw_mis_flag", {63'd0, mis}, 64'd1);
    check("sw_mis_wrs", 64'(wrs), 64'd0);

    // misaligned sh and sd
    run1(2'b01, 64'h105, 64'h1111, lat, wrs, wd, ma, mis, bz);
    check("sh_mis_flag", {63'd0, mis}, 64'd1);
    check("sh_mis_wrs", 64'(wrs), 64'd0);
    run1(2'b11, 64'h10C, 64'h2222, lat, wrs, wd, ma, mis, bz);
    check("sd_mis_flag", {63'd0, mis}, 64'd1);
    check("sd_mis_lat", 64'(lat), 64'd1);

    // aligned sw in upper word
    run1(2'b10, 64'h104, 64'hCAFE_F00D, lat, wrs, wd, ma, mis, bz);
    check("sw_wdata", wd, 64'hCAFE_F00D_5566_7788);
    check("sw_mis", {63'd0, mis}, 64'd0);

    // sd
    run1(2'b11, 64'h108, 64'hDEAD_BEEF_0000_0001, lat, wrs, wd, ma, mis, bz);
    check("sd_wdata", wd, 64'hDEAD_BEEF_0000_0001);
    check("sd_addr", ma, 64'h108);
    check("sd_lat", 64'(lat), 64'(exp_sd_lat));
    check("sd_wrs", 64'(wrs), 64'd1);

    // RD_LATENCY=3 with a second START during READ
    lat = 0; wrs = 0; dones = 0; wd = 64'd0;
    @(negedge clk);
    store_type = 2'b00; addr = 64'h100; reg_data = 64'h5A; start3 = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start3 = (k == 2);
      if (mem_wr3) begin
        wrs++;
        wd = mem_wdata3;
      end
      if (done3) begin
        dones++;
        if (lat == 0) lat = k;
      end
    end
    start3 = 1'b0;
    check("l3_lat", 64'(lat), 64'd5);
    check("l3_wrs", 64'(wrs), 64'd1);
    check("l3_dones", 64'(dones), 64'd1);
    check("l3_wdata", wd, 64'h1122_3344_5566_775A);

    // reset during READ
    @(negedge clk);
    store_type = 2'b00; addr = 64'h101; reg_data = 64'h77; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    @(negedge clk);
    check("rr_busy_pre", {63'd0, busy3}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("rr_busy", {63'd0, busy3}, 64'd0);
    check("rr_wr", {63'd0, mem_wr3}, 64'd0);
    check("rr_addr", mem_addr3, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wrs = 0; dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_wr3) wrs++;
      if (done3) dones++;
    end
    check("rr_no_wr", 64'(wrs), 64'd0);
    check("rr_no_done", 64'(dones), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
